// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding, clock
// frequency for ms-to-cycle conversion, and timer sizing helpers.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int unsigned CLK_FREQ_HZ = 32'd100_000_000;

  // Converts a duration in milliseconds into clk cycles at CLK_FREQ_HZ.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_FREQ_HZ / 32'd1000) * ms;
  endfunction

  // Timer width able to hold max(hold, gap) - 1, never narrower than 1 bit.
  function automatic int unsigned timer_width(input int unsigned hold,
                                              input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    if (m <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(m);
    end
  endfunction

endpackage

// File: rtl/pulse_stretch_cycle_timer.sv
// Loadable down-counter. Stops at zero (no wrap); load has priority over
// counting. done flags the zero count.
module pulse_stretch_cycle_timer #(
  parameter int unsigned TW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic [TW-1:0] count,
  output logic          done
);

  // Count register: load, else decrement while enabled and non-zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= {TW{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != {TW{1'b0}})) begin
      count <= count - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign done = (count == {TW{1'b0}});

endmodule

// File: rtl/pulse_stretch.sv
// Turns 1-cycle strobes into fixed-length levels. Strobes that arrive while
// a level is being shown are queued (or retrigger the hold) and replayed
// with a forced low gap between them.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10_000_000,
  parameter int unsigned GAP_CYCLES  = 2_000_000,
  parameter int unsigned PEND_MAX    = 15,
  parameter int unsigned RETRIGGER   = 0,
  localparam int unsigned PW         = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pulse,
  input  logic          i_clear,
  output logic          o_level,
  output logic          o_busy,
  output logic [PW-1:0] o_pend_cnt,
  output logic          o_overflow
);

  localparam int unsigned TW        = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_TOP  = PW'(PEND_MAX);
  localparam logic [PW-1:0] PEND_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PEND_ZERO = {PW{1'b0}};
  localparam bit            RETRIG    = (RETRIGGER != 32'd0);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pend;
  logic [PW-1:0] pend_nxt;
  logic          ovf_nxt;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic [TW-1:0] tmr_count;
  logic          tmr_done;
  logic          tmr_end;

  pulse_stretch_cycle_timer #(
    .TW(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .en      (tmr_en),
    .count   (tmr_count),
    .done    (tmr_done)
  );

  // Terminal cycle of the current HOLD/GAP phase: the timer sits at zero.
  assign tmr_end = tmr_done && (tmr_count == {TW{1'b0}});

  // Next-state, queue and timer-control decode; clear overrides everything.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    ovf_nxt   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = {TW{1'b0}};
    tmr_en    = 1'b0;
    if (i_clear) begin
      state_nxt = ST_IDLE;
      pend_nxt  = PEND_ZERO;
      tmr_load  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_pulse) begin
            state_nxt = ST_HOLD;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          tmr_en = 1'b1;
          if (RETRIG && i_pulse) begin
            // Retrigger: restart the hold, reload beats the terminal exit.
            state_nxt = ST_HOLD;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LOAD;
          end else begin
            if (!RETRIG && i_pulse) begin
              if (pend < PEND_TOP) begin
                pend_nxt = pend + PEND_ONE;
              end else begin
                ovf_nxt = 1'b1;
              end
            end else begin
              pend_nxt = pend;
            end
            // A strobe counted on the terminal cycle already steers to GAP.
            if (tmr_end) begin
              if (pend_nxt != PEND_ZERO) begin
                state_nxt = ST_GAP;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LOAD;
              end else begin
                state_nxt = ST_IDLE;
              end
            end else begin
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_GAP: begin
          tmr_en = 1'b1;
          if (tmr_end) begin
            state_nxt = ST_HOLD;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LOAD;
            // Incoming strobe cancels the dequeue, so it can never be dropped.
            if (!RETRIG && i_pulse) begin
              pend_nxt = pend;
            end else if (pend != PEND_ZERO) begin
              pend_nxt = pend - PEND_ONE;
            end else begin
              pend_nxt = pend;
            end
          end else begin
            state_nxt = ST_GAP;
            if (!RETRIG && i_pulse) begin
              if (pend < PEND_TOP) begin
                pend_nxt = pend + PEND_ONE;
              end else begin
                ovf_nxt = 1'b1;
              end
            end else begin
              pend_nxt = pend;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          pend_nxt  = PEND_ZERO;
        end
      endcase
    end
  end

  // State, queue count and registered outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pend       <= PEND_ZERO;
      o_level    <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend       <= pend_nxt;
      o_level    <= (state_nxt == ST_HOLD);
      o_busy     <= (state_nxt != ST_IDLE);
      o_overflow <= ovf_nxt;
    end
  end

  assign o_pend_cnt = pend;

endmodule
